// File: rtl/pc_gen_pkg.sv
// Shared types for the PC generator: FSM states, redirect kinds, default reset vector
// and the redirect merge priority used by the hold logic.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_EXC  = 2'd2
  } redir_kind_e;

  localparam logic [31:0] PC_RESET_ADDR_DEFAULT = 32'h1C00_0000;

  // A live exception always wins; a live branch wins unless an exception is already parked.
  function automatic logic live_wins(input redir_kind_e live_kind, input redir_kind_e pend_kind);
    return (live_kind == RD_EXC) || ((live_kind == RD_BR) && (pend_kind != RD_EXC));
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: redirect requests in, fetch PC and status out.
// dbg_state mirrors the generator FSM for observation.
interface pc_gen_if import pc_pkg::*; #(
  parameter int WIDTH = 32
);
  // Handshake: pc is offered whenever pc_valid is high and is consumed on a rising
  // edge where fetch_ready is high and stall is low; pc never changes unless consumed.
  logic             stall;
  logic             fetch_ready;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             exc_valid;
  logic [WIDTH-1:0] exc_target;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             redirect_taken;
  logic             align_err;
  pc_state_e        dbg_state;

  modport master (
    output stall, fetch_ready, br_valid, br_target, exc_valid, exc_target,
    input  pc, pc_valid, redirect_taken, align_err, dbg_state
  );

  modport slave (
    input  stall, fetch_ready, br_valid, br_target, exc_valid, exc_target,
    output pc, pc_valid, redirect_taken, align_err, dbg_state
  );

endinterface

// File: rtl/pc_redirect_hold.sv
// Pending-redirect register: parks a redirect that could not be taken yet and merges
// newer requests into it, exposing the current winner to the PC generator.
module pc_redirect_hold import pc_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_advance,
  input  redir_kind_e      i_live_kind,
  input  logic [WIDTH-1:0] i_live_target,
  output redir_kind_e      o_win_kind,
  output logic [WIDTH-1:0] o_win_target
);

  redir_kind_e      r_pend_kind;
  logic [WIDTH-1:0] r_pend_target;

  always_comb begin
    o_win_kind   = r_pend_kind;
    o_win_target = r_pend_target;
    if (live_wins(i_live_kind, r_pend_kind)) begin
      o_win_kind   = i_live_kind;
      o_win_target = i_live_target;
    end
  end

  // The winner is consumed on advance; otherwise it becomes the new pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_kind   <= RD_NONE;
      r_pend_target <= '0;
    end else if (i_advance) begin
      r_pend_kind   <= RD_NONE;
      r_pend_target <= '0;
    end else begin
      r_pend_kind   <= o_win_kind;
      r_pend_target <= o_win_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential stepping, prioritised branch/exception redirects with
// a pending slot while fetch is held. Define PC_GEN_ALIGN_CHK_EN to enable target alignment checks.
module pc_gen import pc_pkg::*; #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR_DEFAULT),
  parameter int               STEP       = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_state_e        r_state;
  pc_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic             r_redirect_taken;
  logic             w_active;
  logic             w_advance;
  logic             w_br_misaligned;
  logic             w_br_live;
  logic [WIDTH-1:0] w_exc_target;
  redir_kind_e      w_live_kind;
  logic [WIDTH-1:0] w_live_target;
  redir_kind_e      w_win_kind;
  logic [WIDTH-1:0] w_win_target;

  assign w_active  = (r_state != ST_BOOT);
  assign w_advance = w_active && bus.fetch_ready && !bus.stall;

`ifdef PC_GEN_ALIGN_CHK_EN
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
  logic r_align_err;

  assign w_br_misaligned = |(bus.br_target & LOW_MASK);
  assign w_exc_target    = bus.exc_target & ~LOW_MASK;

  // Misaligned branches are dropped outright and only reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_align_err <= 1'b0;
    else     r_align_err <= w_active && bus.br_valid && w_br_misaligned;
  end

  assign bus.align_err = r_align_err;
`else
  assign w_br_misaligned = 1'b0;
  assign w_exc_target    = bus.exc_target;
  assign bus.align_err   = 1'b0;
`endif

  assign w_br_live = bus.br_valid && !w_br_misaligned;

  // Redirect inputs are ignored until the boot cycle has passed.
  always_comb begin
    w_live_kind   = RD_NONE;
    w_live_target = '0;
    if (w_active) begin
      if (bus.exc_valid) begin
        w_live_kind   = RD_EXC;
        w_live_target = w_exc_target;
      end else if (w_br_live) begin
        w_live_kind   = RD_BR;
        w_live_target = bus.br_target;
      end
    end
  end

  pc_redirect_hold #(.WIDTH(WIDTH)) u_hold (
    .clk           (clk),
    .rst           (rst),
    .i_advance     (w_advance),
    .i_live_kind   (w_live_kind),
    .i_live_target (w_live_target),
    .o_win_kind    (w_win_kind),
    .o_win_target  (w_win_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (w_advance)                    w_state_nxt = ST_RUN;
        else if (w_win_kind != RD_NONE)   w_state_nxt = ST_HOLD;
        else                              w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc             <= RESET_ADDR;
      r_redirect_taken <= 1'b0;
    end else begin
      r_redirect_taken <= 1'b0;
      if (w_advance) begin
        if (w_win_kind != RD_NONE) begin
          r_pc             <= w_win_target;
          r_redirect_taken <= 1'b1;
        end else begin
          r_pc <= r_pc + STEP_W;
        end
      end
    end
  end

  assign bus.pc             = r_pc;
  assign bus.pc_valid       = w_active;
  assign bus.redirect_taken = r_redirect_taken;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus a randomised run, all expectations queued
// at drive time and compared one cycle later against the DUT outputs.
`timescale 1ns/1ps
module tb_pc_gen;
  import pc_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 3;
  localparam logic [W-1:0] B = 32'h1C00_0000;

  logic clk = 1'b0;
  logic rst;

  pc_gen_if #(.WIDTH(W)) bus ();

  pc_gen #(.WIDTH(W), .RESET_ADDR(B), .STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fr, input logic bv, input logic [W-1:0] bt,
                       input logic ev, input logic [W-1:0] et);
    bus.stall       = st;
    bus.fetch_ready = fr;
    bus.br_valid    = bv;
    bus.br_target   = bt;
    bus.exc_valid   = ev;
    bus.exc_target  = et;
  endtask

  task automatic tick(input string tag);
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got pc %08h", tag, bus.pc);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pc"},    bus.pc,                 e[EW-1:3]);
      check({tag, "_valid"}, W'(bus.pc_valid),       W'(e[2]));
      check({tag, "_rt"},    W'(bus.redirect_taken), W'(e[1]));
      check({tag, "_ae"},    W'(bus.align_err),      W'(e[0]));
    end
  endtask

  task automatic step(input logic st, input logic fr, input logic bv, input logic [W-1:0] bt,
                      input logic ev, input logic [W-1:0] et,
                      input logic [W-1:0] e_pc, input logic e_rt, input logic e_ae, input string tag);
    drive(st, fr, bv, bt, ev, et);
    exp_q.push_back({e_pc, 1'b1, e_rt, e_ae});
    tick(tag);
  endtask

  task automatic check_state(input string tag, input pc_state_e s);
    check(tag, W'(bus.dbg_state), W'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] last_pc;
    logic [W-1:0] m_pc, m_pt, bt, et, lt, wt;
    int m_pk, lk, wk;
    bit m_run;
    logic st, fr, bv, ev, rt;

    // Reset and boot cycle
    drive(0, 1, 0, '0, 0, '0);
    rst = 1'b1;
    #3;
    check("rst_pc", bus.pc, B);
    check("rst_valid", W'(bus.pc_valid), '0);
    check("rst_rt", W'(bus.redirect_taken), '0);
    check("rst_ae", W'(bus.align_err), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("boot_valid", W'(bus.pc_valid), '0);
    check_state("boot_state", ST_BOOT);

    // Sequential fetch
    step(0, 1, 0, '0, 0, '0, B,        0, 0, "seq0");
    step(0, 1, 0, '0, 0, '0, B + 'h4,  0, 0, "seq1");
    step(0, 1, 0, '0, 0, '0, B + 'h8,  0, 0, "seq2");

    // Immediate branch
    step(0, 1, 1, B + 'h100, 0, '0, B + 'h100, 1, 0, "br_imm");
    step(0, 1, 0, '0, 0, '0,        B + 'h104, 0, 0, "br_after");

    // Pending priority under stall: br, exc, br -> exc wins
    step(1, 1, 1, B + 'h200, 0, '0,        B + 'h104, 0, 0, "hold_br");
    check_state("hold_state", ST_HOLD);
    step(1, 1, 0, '0,        1, B + 'h800, B + 'h104, 0, 0, "hold_exc");
    step(1, 1, 1, B + 'h300, 0, '0,        B + 'h104, 0, 0, "hold_br2");
    step(0, 1, 0, '0,        0, '0,        B + 'h800, 1, 0, "hold_rel");
    check_state("run_state", ST_RUN);
    step(0, 1, 0, '0, 0, '0, B + 'h804, 0, 0, "hold_after");

    // fetch_ready low holds; pending exc beats a later live br
    step(0, 0, 0, '0,        0, '0,        B + 'h804, 0, 0, "fr_low");
    step(0, 0, 0, '0,        1, B + 'h900, B + 'h804, 0, 0, "fr_low_exc");
    step(0, 1, 1, B + 'hA00, 0, '0,        B + 'h900, 1, 0, "pend_exc_vs_br");
    // Newer br replaces a pending br
    step(1, 1, 1, B + 'hB00, 0, '0,        B + 'h900, 0, 0, "pend_br");
    step(0, 1, 1, B + 'hC00, 0, '0,        B + 'hC00, 1, 0, "br_replace");
    // Simultaneous live exc and br
    step(0, 1, 1, B + 'hD00, 1, B + 'hE00, B + 'hE00, 1, 0, "exc_over_br");
    // Live exc replaces a pending br
    step(1, 1, 1, B + 'hF00, 0, '0,         B + 'hE00,  0, 0, "pend_br2");
    step(0, 1, 0, '0,        1, B + 'h1000, B + 'h1000, 1, 0, "exc_replace");
    step(1, 1, 0, '0,        0, '0,         B + 'h1000, 0, 0, "stall_idle");
    step(0, 1, 0, '0,        0, '0,         B + 'h1004, 0, 0, "stall_rel");

    // Wrap at the top of the address space
    step(0, 1, 1, 32'hFFFF_FFFC, 0, '0, 32'hFFFF_FFFC, 1, 0, "wrap_br");
    step(0, 1, 0, '0, 0, '0, 32'h0000_0000, 0, 0, "wrap");
    step(0, 1, 0, '0, 0, '0, 32'h0000_0004, 0, 0, "wrap_next");

    // Target alignment
`ifdef PC_GEN_ALIGN_CHK_EN
    step(0, 1, 1, B + 'h102, 0, '0,        32'h0000_0008, 0, 1, "misalign_br");
    step(0, 1, 0, '0,        0, '0,        32'h0000_000C, 0, 0, "misalign_after");
    step(0, 1, 0, '0,        1, B + 'h803, B + 'h800,     1, 0, "exc_mask");
    step(1, 1, 1, B + 'h102, 0, '0,        B + 'h800,     0, 1, "misalign_stall");
    step(0, 1, 0, '0,        0, '0,        B + 'h804,     0, 0, "misalign_nocap");
    last_pc = B + 'h804;
`else
    step(0, 1, 1, B + 'h102, 0, '0,        B + 'h102, 1, 0, "raw_br");
    step(0, 1, 0, '0,        0, '0,        B + 'h106, 0, 0, "raw_br_after");
    step(0, 1, 0, '0,        1, B + 'h803, B + 'h803, 1, 0, "raw_exc");
    step(0, 1, 0, '0,        0, '0,        B + 'h807, 0, 0, "raw_exc_after");
    last_pc = B + 'h807;
`endif

    // Reset in the middle of HOLD with a pending exc
    step(1, 1, 0, '0, 1, B + 'h800, last_pc, 0, 0, "pre_rst_hold");
    check_state("pre_rst_state", ST_HOLD);
    drive(0, 1, 0, '0, 0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pc", bus.pc, B);
    check("midrst_valid", W'(bus.pc_valid), '0);
    check_state("midrst_state", ST_BOOT);
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 1, 1, B + 'h500, 0, '0, B,       0, 0, "boot_ignore");
    check_state("boot_run", ST_RUN);
    step(0, 1, 0, '0,        0, '0, B + 'h4, 0, 0, "resume");

    // Reset right after a redirect clears the pulse
    step(0, 1, 0, '0, 1, B + 'h300, B + 'h300, 1, 0, "exc_imm");
    #2;
    rst = 1'b1;
    #1;
    check("rst_rt_clear", W'(bus.redirect_taken), '0);
    check("rst_pc2", bus.pc, B);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomised run against a behavioural model
    m_pc = B; m_pt = '0; m_pk = 0; m_run = 0;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 3) == 0);
      fr = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 3) == 0);
      ev = ($urandom_range(0, 6) == 0);
      bt = B + (W'($urandom_range(0, 1023)) << 2);
      et = B + 32'h0010_0000 + (W'($urandom_range(0, 1023)) << 2);
      rt = 1'b0;
      if (!m_run) begin
        m_run = 1;
      end else begin
        lk = ev ? 2 : (bv ? 1 : 0);
        lt = ev ? et : bt;
        wk = m_pk;
        wt = m_pt;
        if (lk == 2 || (lk == 1 && m_pk != 2)) begin
          wk = lk;
          wt = lt;
        end
        if (fr && !st) begin
          if (wk != 0) begin
            m_pc = wt;
            rt   = 1'b1;
          end else begin
            m_pc = m_pc + 32'd4;
          end
          m_pk = 0;
        end else begin
          m_pk = wk;
          m_pt = wt;
        end
      end
      step(st, fr, bv, bt, ev, et, m_pc, rt, 0, $sformatf("rand%0d", i));
    end

    check("sb_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
